ripple4_sub_serial: RTL and testbench



---
 rtl/ripple4_sub_serial.sv | 134 +++++++++++++
 tb/tb_ripple4_sub_serial.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ripple4_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : ripple4_sub_serial
// Brief    : Bit-serial ripple subtractor, outD = inA - inB - Bin, LSB first,
//            with valid/ready handshakes on operands and result.
//            Optional signed-overflow output enabled by RIPPLE4_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ripple4_sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outD,
    output logic             Bout,
    output logic             busy
`ifdef RIPPLE4_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_ONE   = c_IDX_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_outd;
    logic               r_borrow;
    logic               r_bout;
    logic [c_IDX_W-1:0] r_idx;

    logic w_accept;
    logic w_run;
    logic w_a;
    logic w_b;
    logic w_d;
    logic w_br;

    assign w_accept = (r_state == c_IDLE) && in_valid;
    assign w_run    = (r_state == c_RUN);

    // Operands shift right each RUN cycle, so bit 0 is always bit idx.
    assign w_a  = r_a[0];
    assign w_b  = r_b[0];
    assign w_d  = w_a ^ w_b ^ r_borrow;
    assign w_br = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)         w_next = c_RUN;
            c_RUN:   if (r_idx == c_LAST)  w_next = c_DONE;
            c_DONE:  if (out_ready)        w_next = c_IDLE;
            default:                       w_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
        busy      = (r_state != c_IDLE);
    end

`ifdef RIPPLE4_SUB_OVF_EN
    logic r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_outd   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_idx    <= '0;
`ifdef RIPPLE4_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a      <= inA;
            r_b      <= inB;
            r_borrow <= Bin;
            r_idx    <= '0;
            r_res    <= '0;
        end else if (w_run) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_br;
            r_idx    <= r_idx + c_ONE;
            r_res    <= {w_d, r_res[WIDTH-1:1]};
            if (r_idx == c_LAST) begin
                r_outd <= {w_d, r_res[WIDTH-1:1]};
                r_bout <= w_br;
`ifdef RIPPLE4_SUB_OVF_EN
                // On the last step w_a/w_b are the operand MSBs and w_d the result MSB.
                r_ovf  <= (w_a != w_b) && (w_d != w_a);
`endif
            end
        end
    end

    assign outD = r_outd;
    assign Bout = r_bout;
`ifdef RIPPLE4_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ripple4_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple4_sub_serial
// Brief    : Self-checking bench for ripple4_sub_serial (vector table, reset
//            abort sequence, randomized operations against an arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ripple4_sub_serial;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        int           hold;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] outD;
    logic         Bout;
    logic         busy;
`ifdef RIPPLE4_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ripple4_sub_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inA       (inA),
        .inB       (inB),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outD      (outD),
        .Bout      (Bout),
        .busy      (busy)
`ifdef RIPPLE4_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned and signed views.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        vec_t v;
        int   diff;
        int   sa;
        int   sb;
        int   sdiff;
        diff  = int'(a) - int'(b) - int'(bin);
        sa    = (int'(a) >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
        sb    = (int'(b) >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
        sdiff = sa - sb - int'(bin);
        v.a    = a;
        v.b    = b;
        v.bin  = bin;
        v.d    = W'((diff + (1 << W)) % (1 << W));
        v.bout = (diff < 0);
        v.ovf  = (sdiff < -(1 << (W - 1))) || (sdiff > (1 << (W - 1)) - 1);
        v.hold = 0;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        inA       = v.a;
        inB       = v.b;
        Bin       = v.bin;
        in_valid  = 1'b1;
        out_ready = (v.hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        inA      = W'($urandom);
        inB      = W'($urandom);
        Bin      = 1'($urandom);
        check({tag, " busy/in_ready after accept"}, {30'd0, busy, in_ready}, 32'h2);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 3 * W) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(W));
        check({tag, " outD"}, 32'(outD), 32'(v.d));
        check({tag, " Bout"}, 32'(Bout), 32'(v.bout));
`ifdef RIPPLE4_SUB_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
`endif
        for (int i = 0; i < v.hold; i++) begin
            in_valid = 1'b1;
            inA      = W'($urandom);
            inB      = W'($urandom);
            @(posedge clk); #1;
            check({tag, " hold {out_valid,Bout,outD}"}, {27'd0, out_valid, Bout, outD},
                  {27'd0, 1'b1, v.bout, v.d});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " retire {out_valid,busy,in_ready}"}, {29'd0, out_valid, busy, in_ready}, 32'h1);
        check({tag, " outD kept"}, 32'(outD), 32'(v.d));
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            a     b     bin   d     bout  ovf   hold
        vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0, 0};
        vecs[1] = '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0, 0};
        vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 0};
        vecs[3] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 0};
        vecs[4] = '{4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 0};
        vecs[5] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0, 1};
        vecs[6] = '{4'h9, 4'h4, 1'b0, 4'h5, 1'b0, 1'b1, 10};

        rst       = 1'b1;
        in_valid  = 1'b0;
        inA       = '0;
        inB       = '0;
        Bin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset {in_ready,out_valid,busy,Bout,outD}",
              {24'd0, in_ready, out_valid, busy, Bout, outD}, 32'h80);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort mid-operation: outD still holds 0x5 from the previous vector.
        inA      = 4'hF;
        inB      = 4'h1;
        Bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort {in_ready,out_valid,busy,Bout,outD}",
              {24'd0, in_ready, out_valid, busy, Bout, outD}, 32'h80);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op('{4'h7, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 0}, "after_abort");

        for (int i = 0; i < 20; i++) begin
            rv      = model(W'($urandom), W'($urandom), 1'($urandom));
            rv.hold = int'($urandom_range(0, 2));
            run_op(rv, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
